// File: rtl/neuron_mac_pkg.sv
// Shared types and constants for the neuron pre-activation MAC.
// Build option: NEURON_MAC_SAT_EN selects saturating accumulation (default wraps).
package neuron_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    CONVERT,
    OUTPUT
  } mac_state_t;

  localparam int FRAC_BITS   = 8;
  localparam int FP_EXP_BIAS = 127;
  localparam int FP_MANT_W   = 23;

endpackage

// File: rtl/neuron_mac_if.sv
// Control, operand stream and result handshake between a neuron MAC and its driver.
interface neuron_mac_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 9
);

  logic              start;
  logic [CNT_W-1:0]  n_inputs;
  logic [DATA_W-1:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x_in;
  logic [DATA_W-1:0] w_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_float;
  logic              busy;
  logic              ovf;

  modport master (
    output start, n_inputs, bias, in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, out_float, busy, ovf
  );

  modport slave (
    input  start, n_inputs, bias, in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, out_float, busy, ovf
  );

endinterface

// File: rtl/neuron_mac_acc_to_float.sv
// Combinational conversion of a signed fixed-point accumulator (2*FRAC fraction bits)
// to IEEE-754 single, truncating toward zero.
module neuron_mac_acc_to_float
  import neuron_mac_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int FRAC  = FRAC_BITS
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [31:0]      float_o
);

  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] norm;
  logic [7:0]       exp_field;
  int               msb;

  // The most-negative accumulator value still has a correct unsigned magnitude here.
  always_comb begin
    mag = acc_i[ACC_W-1] ? -acc_i : acc_i;
    msb = 0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) msb = i;
    end
    norm      = mag << (ACC_W - 1 - msb);
    exp_field = 8'(FP_EXP_BIAS + msb - 2 * FRAC);
    float_o   = {acc_i[ACC_W-1], exp_field, norm[ACC_W-2 -: FP_MANT_W]};
    if (mag == '0) float_o = '0;
  end

endmodule

// File: rtl/neuron_mac.sv
// One-neuron pre-activation: sum(x*w)+bias in fixed point, emitted as IEEE-754 single.
// Build option: NEURON_MAC_SAT_EN clamps the accumulator on overflow instead of wrapping.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 9
) (
  input logic           clk,
  input logic           reset_n,
  neuron_mac_if.slave   mac_s
);

  localparam int FRAC   = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  mac_state_t                state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      prod_vld_q, prod_vld_d;
  logic [31:0]               float_q, float_d;
  logic                      ovf_q, ovf_d;

  logic signed [ACC_W-1:0]   addend;
  logic signed [ACC_W-1:0]   sum;
  logic                      add_ovf;
  logic [31:0]               conv_float;

  neuron_mac_acc_to_float #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_acc_to_float (
    .acc_i   (acc_q),
    .float_o (conv_float)
  );

  assign addend  = ACC_W'(prod_q);
  assign sum     = acc_q + addend;
  assign add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

  assign mac_s.in_ready  = (state_q == ACCUM);
  assign mac_s.out_valid = (state_q == OUTPUT);
  assign mac_s.out_float = float_q;
  assign mac_s.busy      = (state_q != IDLE);
  assign mac_s.ovf       = ovf_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    float_d    = float_q;
    ovf_d      = ovf_q;

    // The pending product is folded in while the next pair is being multiplied.
    if (prod_vld_q) begin
      ovf_d = ovf_q | add_ovf;
`ifdef NEURON_MAC_SAT_EN
      if (add_ovf) begin
        acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = sum;
      end
`else
      acc_d = sum;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (mac_s.start) begin
          acc_d   = ACC_W'($signed(mac_s.bias)) << FRAC;
          ovf_d   = 1'b0;
          count_d = mac_s.n_inputs;
          state_d = (mac_s.n_inputs == '0) ? CONVERT : ACCUM;
        end
      end
      ACCUM: begin
        if (mac_s.in_valid) begin
          prod_d     = PROD_W'($signed(mac_s.x_in)) * PROD_W'($signed(mac_s.w_in));
          prod_vld_d = 1'b1;
          count_d    = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = CONVERT;
      end
      CONVERT: begin
        float_d = conv_float;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (mac_s.out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      float_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      float_q    <= float_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
